// File: rtl/micro80_video_pkg.sv
// Shared constants and types for the Micro-80 character video path.
package micro80_video_pkg;

    // Timing of the HDMI stage that drives hcnt/vcnt
    localparam int H_START = 160;
    localparam int V_START = 29;
    localparam int H_TOTAL = 1344;

    // Character screen geometry
    localparam int COLS    = 64;
    localparam int ROWS    = 32;
    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 8;
    localparam int HSCALE  = 2;
    localparam int VSCALE  = 3;

    localparam int H_ACTIVE      = COLS * GLYPH_W * HSCALE;   // 1024 pixels
    localparam int LINES_PER_ROW = GLYPH_H * VSCALE;          // 24 scan lines

    // Lookahead between the fetch address and the displayed pixel; covers
    // the VRAM and font ROM latencies plus the code/font registers.
    localparam int LEAD = 5;

    typedef logic [23:0] rgb24_t;   // {R,G,B}

    localparam rgb24_t DEFAULT_FG_RGB     = 24'h00FF00;
    localparam rgb24_t DEFAULT_BG_RGB     = 24'h000000;
    localparam int     DEFAULT_BLINK_LOG2 = 4;

endpackage

// File: rtl/micro80_cursor_blink.sv
// Cursor blink phase: counts rising edges of vs and flips the phase each
// time the frame counter wraps.
module micro80_cursor_blink
    import micro80_video_pkg::*;
#(
    parameter int BLINK_LOG2 = DEFAULT_BLINK_LOG2
) (
    input  logic pixclk,
    input  logic rst,
    input  logic vs,
    output logic blink
);

    logic                  vs_q;
    logic [BLINK_LOG2-1:0] frame_cnt;

    // Detect vs rising edges and advance the frame counter / blink phase
    always_ff @(posedge pixclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            vs_q      <= 1'b0;
            frame_cnt <= '0;
            blink     <= 1'b0;
        end else begin
            vs_q <= vs;
            if (vs && !vs_q) begin
                frame_cnt <= frame_cnt + 1'b1;
                if (frame_cnt == {BLINK_LOG2{1'b1}})
                    blink <= ~blink;
            end
        end
    end

endmodule

// File: rtl/micro80_text_gen.sv
// Micro-80 character-mode pixel generator: 64x32 cells of 8x8 glyphs,
// scaled 2x3, fetched from VRAM/font ROM ahead of the beam and serialised
// into RGB for the HDMI stage.
module micro80_text_gen
    import micro80_video_pkg::*;
#(
    parameter rgb24_t FG_RGB     = DEFAULT_FG_RGB,
    parameter rgb24_t BG_RGB     = DEFAULT_BG_RGB,
    parameter int     BLINK_LOG2 = DEFAULT_BLINK_LOG2
) (
    input  logic        pixclk,
    input  logic        rst,
    input  logic [10:0] hcnt,
    input  logic [10:0] vcnt,
    input  logic        visible,
    input  logic        vs,
    output logic [10:0] vram_addr,
    input  logic [7:0]  vram_data,
    output logic [9:0]  font_addr,
    input  logic [7:0]  font_data,
    input  logic [5:0]  cursor_x,
    input  logic [4:0]  cursor_y,
    input  logic        cursor_en,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue
);

    localparam logic [11:0] H_FIRST   = 12'(H_START);
    localparam logic [11:0] X_LIMIT   = 12'(H_ACTIVE);
    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_PRE     = 11'(V_START - 1);
    localparam logic [4:0]  SUB_LAST  = 5'(LINES_PER_ROW - 1);
    localparam logic [4:0]  ROW_LAST  = 5'(ROWS - 1);
    localparam logic [1:0]  VDIV_LAST = 2'(VSCALE - 1);

    // Vertical state: counts scan lines inside the active window
    logic       v_active;
    logic [4:0] row;
    logic [4:0] sub;
    logic [1:0] vdiv;
    logic [2:0] glyph_line;

    // Fetch and display pipeline
    logic       code7_q;
    logic       inv_d;
    logic       inv_q;
    logic [7:0] shift;
    rgb24_t     rgb_q;
    logic       blink;

    // Column arithmetic; columns left of the window wrap to large values
    logic [11:0] x_cur;
    logic [11:0] x_nxt;
    logic [11:0] x_la;
    logic        cur_in;
    logic        la_in;
    logic        load_cell;
    logic        line_end;
    logic        cursor_hit;
    logic        pix;

    assign x_cur     = {1'b0, hcnt} - H_FIRST;
    assign x_nxt     = x_cur + 12'd1;
    assign x_la      = x_cur + 12'(LEAD);
    assign cur_in    = x_cur < X_LIMIT;
    assign la_in     = x_la < X_LIMIT;
    assign load_cell = (x_nxt < X_LIMIT) && (x_nxt[3:0] == 4'd0);
    assign line_end  = hcnt == H_LAST;

    assign cursor_hit = cursor_en && blink && (row == cursor_y)
                        && (x_cur[9:4] == cursor_x) && (glyph_line >= 3'd6);
    assign pix        = shift[7] ^ inv_q ^ cursor_hit;

    micro80_cursor_blink #(
        .BLINK_LOG2 (BLINK_LOG2)
    ) u_cursor_blink (
        .pixclk (pixclk),
        .rst    (rst),
        .vs     (vs),
        .blink  (blink)
    );

    // Row / sub-line / glyph-line tracking, advanced at each line end
    always_ff @(posedge pixclk) begin
        // NOTE: reset is synchronous, so rst is simply sampled at the clock edge like any other input.
        if (rst) begin
            v_active   <= 1'b0;
            row        <= '0;
            sub        <= '0;
            vdiv       <= '0;
            glyph_line <= '0;
        end else if (line_end) begin
            if (vcnt == V_PRE) begin
                v_active   <= 1'b1;
                row        <= '0;
                sub        <= '0;
                vdiv       <= '0;
                glyph_line <= '0;
            end else if (v_active) begin
                if (sub == SUB_LAST) begin
                    sub        <= '0;
                    vdiv       <= '0;
                    glyph_line <= '0;
                    row        <= row + 5'd1;
                    if (row == ROW_LAST)
                        v_active <= 1'b0;
                end else begin
                    sub <= sub + 5'd1;
                    if (vdiv == VDIV_LAST) begin
                        vdiv       <= '0;
                        glyph_line <= glyph_line + 3'd1;
                    end else begin
                        vdiv <= vdiv + 2'd1;
                    end
                end
            end
        end
    end

    // Fetch: VRAM address from the lookahead column, then font address from the code
    always_ff @(posedge pixclk) begin
        if (rst) begin
            vram_addr <= '0;
            font_addr <= '0;
            code7_q   <= 1'b0;
            inv_d     <= 1'b0;
        end else begin
            if (v_active && la_in)
                vram_addr <= {row, x_la[9:4]};
            font_addr <= {vram_data[6:0], glyph_line};
            code7_q   <= vram_data[7];
            inv_d     <= code7_q;
        end
    end

    // Display: load the glyph row at each cell boundary, shift every 2nd pixel, colour it
    always_ff @(posedge pixclk) begin
        if (rst) begin
            shift <= '0;
            inv_q <= 1'b0;
            rgb_q <= '0;
        end else begin
            if (load_cell) begin
                shift <= font_data;
                inv_q <= inv_d;
            end else if (x_cur[0]) begin
                shift <= {shift[6:0], 1'b0};
            end
            if (v_active && cur_in)
                rgb_q <= pix ? FG_RGB : BG_RGB;
            else
                rgb_q <= '0;
        end
    end

    // visible is registered alongside rgb_q in the HDMI stage, so it blanks the same pixel
    assign red   = visible ? rgb_q[23:16] : 8'h00;
    assign green = visible ? rgb_q[15:8]  : 8'h00;
    assign blue  = visible ? rgb_q[7:0]   : 8'h00;

endmodule

// File: tb/tb_micro80_text_gen.sv
// Directed testbench for micro80_text_gen with VRAM and font ROM models.
module tb_micro80_text_gen;

    localparam int LEAD    = 5;
    localparam int M_MODEL = 0;
    localparam int M_ZERO  = 1;
    localparam logic [23:0] FG = 24'h00FF00;
    localparam logic [23:0] BG = 24'h000000;

    logic        pixclk;
    logic        rst;
    logic [10:0] hcnt;
    logic [10:0] vcnt;
    logic        visible;
    logic        vs;
    logic [10:0] vram_addr;
    logic [7:0]  vram_data;
    logic [9:0]  font_addr;
    logic [7:0]  font_data;
    logic [5:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        cursor_en;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic [23:0] rgb_obs;

    logic [7:0]  vram [0:2047];
    logic [7:0]  font [0:1023];
    logic [23:0] line_rgb  [0:1343];
    logic [10:0] line_addr [0:1343];
    logic        blink_exp;

    int checks;
    int errors;

    assign rgb_obs = {red, green, blue};

    micro80_text_gen dut (
        .pixclk    (pixclk),
        .rst       (rst),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .visible   (visible),
        .vs        (vs),
        .vram_addr (vram_addr),
        .vram_data (vram_data),
        .font_addr (font_addr),
        .font_data (font_data),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .cursor_en (cursor_en),
        .red       (red),
        .green     (green),
        .blue      (blue)
    );

    initial pixclk = 1'b0;
    always #5 pixclk = ~pixclk;

    // Synchronous VRAM and font ROM, one cycle of read latency each
    always @(posedge pixclk) begin
        vram_data <= vram[vram_addr];
        font_data <= font[font_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic in_win(input int h, input int v);
        return (h >= 160) && (h <= 1183) && (v >= 29) && (v <= 796);
    endfunction

    // Reference pixel from screen coordinates
    function automatic logic [23:0] exp_pix(input int h, input int v);
        int x, y, r, c, gl, b;
        logic [7:0] code, g;
        logic p;
        if (!in_win(h, v)) return 24'h0;
        x = h - 160;
        y = v - 29;
        r = y / 24;
        gl = (y % 24) / 3;
        c = x / 16;
        b = (x % 16) / 2;
        code = vram[r * 64 + c];
        g = font[{code[6:0], 3'(gl)}];
        p = g[7 - b] ^ code[7] ^ (cursor_en && blink_exp && (r == int'(cursor_y))
                                  && (c == int'(cursor_x)) && (gl >= 6));
        return p ? FG : BG;
    endfunction

    // One pixel clock: inputs change at negedge, outputs sampled 1 after posedge
    task automatic step(input int h, input int v);
        @(negedge pixclk);
        hcnt = 11'(h);
        vcnt = 11'(v);
        @(posedge pixclk);
        visible = in_win(h, v);
        #1;
    endtask

    task automatic drive_line(input int v, input int h0, input int h1, input int chk_from,
                              input int mode);
        for (int h = h0; h <= h1; h++) begin
            step(h, v);
            line_rgb[h]  = rgb_obs;
            line_addr[h] = vram_addr;
            if (mode == M_MODEL && h >= chk_from)
                check($sformatf("pix h=%0d v=%0d", h, v), rgb_obs, exp_pix(h, v));
            else if (mode == M_ZERO) begin
                check($sformatf("rst_rgb h=%0d v=%0d", h, v), rgb_obs, 0);
                check($sformatf("rst_addr h=%0d v=%0d", h, v), vram_addr, 0);
            end
        end
        step(1343, v);
    endtask

    task automatic skip_lines(input int v0, input int v1);
        for (int v = v0; v <= v1; v++) step(1343, v);
    endtask

    task automatic vs_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            vs = 1'b1;
            step(0, 0);
            vs = 1'b0;
            step(0, 0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        hcnt = '0;
        vcnt = '0;
        visible = 1'b0;
        vs = 1'b0;
        cursor_x = '0;
        cursor_y = '0;
        cursor_en = 1'b0;
        blink_exp = 1'b0;
        for (int i = 0; i < 2048; i++) vram[i] = 8'h41;
        vram[2047] = 8'hC1;
        for (int i = 0; i < 1024; i++) font[i] = 8'h00;
        font[{7'h41, 3'd0}] = 8'h18;
        font[{7'h41, 3'd1}] = 8'h24;
        font[{7'h41, 3'd2}] = 8'h42;
        font[{7'h41, 3'd3}] = 8'h7E;
        font[{7'h41, 3'd4}] = 8'h42;
        font[{7'h41, 3'd5}] = 8'h42;
        font[{7'h41, 3'd6}] = 8'h42;
        for (int i = 0; i < 8; i++) font[{7'h7F, 3'(i)}] = 8'hFF;

        // Power-up reset
        repeat (3) step(0, 0);
        check("init_vram_addr", vram_addr, 0);
        check("init_font_addr", font_addr, 0);
        check("init_rgb", rgb_obs, 0);
        rst = 1'b0;

        // Line 29: 'A' glyph line 0 = 0x18 in every cell
        step(1343, 28);
        drive_line(29, 150, 1190, 150, M_MODEL);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("a_cell0 x=%0d", i), line_rgb[160 + i], (i >= 6 && i <= 9) ? FG : BG);
            check($sformatf("a_cell1 x=%0d", 16 + i), line_rgb[176 + i], (i >= 6 && i <= 9) ? FG : BG);
        end
        check("a_left_border", line_rgb[159], 0);
        check("a_right_border", line_rgb[1184], 0);

        // Line 53 (row 1): VRAM addresses 64..127, LEAD pixels ahead of the beam
        skip_lines(30, 52);
        drive_line(53, 150, 1190, 150, M_MODEL);
        for (int h = 150; h <= 1190; h++) begin
            int ea;
            if (h < 160 - LEAD) ea = 63;
            else if (h <= 1183 - LEAD) ea = 64 + (h - (160 - LEAD)) / 16;
            else ea = 127;
            check($sformatf("addr h=%0d", h), line_addr[h], ea);
        end

        // Row 31: last cell holds inverse 'A'
        skip_lines(54, 772);
        for (int v = 773; v <= 796; v++) begin
            drive_line(v, 1150, 1190, 1168, M_MODEL);
            if (v == 773) begin
                for (int i = 0; i < 16; i++)
                    check($sformatf("inv_cell x=%0d", 1008 + i), line_rgb[1168 + i],
                          (i >= 6 && i <= 9) ? BG : FG);
                check("inv_right_border", line_rgb[1184], 0);
            end
        end

        // Solid font outside the window must stay black
        for (int i = 0; i < 2048; i++) vram[i] = 8'h7F;
        drive_line(797, 150, 1190, 150, M_MODEL);
        drive_line(10, 150, 1190, 150, M_MODEL);
        step(1343, 28);
        drive_line(29, 150, 1190, 150, M_MODEL);
        check("ff_first_px", line_rgb[160], FG);
        check("ff_last_px", line_rgb[1183], FG);
        check("ff_h159", line_rgb[159], 0);
        check("ff_h1184", line_rgb[1184], 0);

        // Mid-line reset: blank and address 0 until the next frame start
        for (int h = 150; h < 600; h++) begin
            step(h, 30);
            check($sformatf("pre_rst h=%0d", h), rgb_obs, exp_pix(h, 30));
        end
        rst = 1'b1;
        for (int h = 600; h < 605; h++) begin
            step(h, 30);
            check($sformatf("in_rst_rgb h=%0d", h), rgb_obs, 0);
            check($sformatf("in_rst_addr h=%0d", h), vram_addr, 0);
        end
        rst = 1'b0;
        drive_line(30, 605, 1190, 605, M_ZERO);
        drive_line(31, 150, 1190, 150, M_ZERO);
        step(1343, 28);
        drive_line(29, 150, 1190, 150, M_MODEL);

        // Cursor at (5,3) over blank cells, blink on after 16 frames
        for (int i = 0; i < 2048; i++) vram[i] = 8'h20;
        cursor_x = 6'd5;
        cursor_y = 5'd3;
        cursor_en = 1'b1;
        vs_pulses(16);
        blink_exp = 1'b1;
        step(1343, 28);
        skip_lines(29, 117);
        drive_line(118, 150, 1190, 150, M_MODEL);
        check("cur_sub17", line_rgb[240], BG);
        for (int v = 119; v <= 124; v++) begin
            drive_line(v, 150, 1190, 150, M_MODEL);
            check($sformatf("cur_on_first v=%0d", v), line_rgb[240], FG);
            check($sformatf("cur_on_last v=%0d", v), line_rgb[255], FG);
            check($sformatf("cur_left v=%0d", v), line_rgb[239], BG);
            check($sformatf("cur_right v=%0d", v), line_rgb[256], BG);
        end

        // After 32 frames in total the cursor is off again
        vs_pulses(16);
        blink_exp = 1'b0;
        step(1343, 28);
        skip_lines(29, 118);
        drive_line(119, 150, 1190, 150, M_MODEL);
        check("cur_off_first", line_rgb[240], BG);
        check("cur_off_last", line_rgb[255], BG);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
